// File: rtl/mult_div_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_sequencer_pkg
//  Description : Shared definitions for the HI/LO multiply/divide sequencer:
//                R-type funct codes, FSM state encoding and step count.
//  Revision    : 1.0  initial release
// ============================================================================
package mult_div_sequencer_pkg;

  // R-type funct codes handled by (or related to) the HI/LO unit
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  // One iteration per operand bit
  localparam int STEP_COUNT = 32;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage : mult_div_sequencer_pkg
`default_nettype wire

// File: rtl/mult_div_sequencer_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_iter
//  Description : One combinational iteration of the sequencer datapath.
//                Multiply: radix-2 shift-add, accumulator = {partial, multiplier}.
//                Divide  : restoring step, accumulator = {remainder, quotient}.
//                The divide path exists only when MULT_DIV_DIVIDE_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_div_iter #(
  parameter int NBITS = 32
) (
`ifdef MULT_DIV_DIVIDE_EN
  input  logic                 i_op_div,
`endif
  input  logic [2*NBITS-1:0]   i_acc,
  input  logic [NBITS-1:0]     i_operand,
  output logic [2*NBITS-1:0]   o_acc
);

  logic [NBITS:0]   w_sum;
`ifdef MULT_DIV_DIVIDE_EN
  logic [NBITS:0]   w_part;
  logic             w_ge;
  logic [NBITS-1:0] w_diff;
`endif

  // Single step: add-and-shift-right for multiply, shift-and-subtract for divide
  always_comb begin
    w_sum = {1'b0, i_acc[2*NBITS-1:NBITS]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    o_acc = {w_sum, i_acc[NBITS-1:1]};
`ifdef MULT_DIV_DIVIDE_EN
    // Remainder stays below the divisor, so the difference always fits NBITS
    w_part = {i_acc[2*NBITS-1:NBITS], i_acc[NBITS-1]};
    w_ge   = (w_part >= {1'b0, i_operand});
    w_diff = w_part[NBITS-1:0] - i_operand;
    if (i_op_div) begin
      o_acc = {(w_ge ? w_diff : w_part[NBITS-1:0]), i_acc[NBITS-2:0], w_ge};
    end
`endif
  end

endmodule : mult_div_iter
`default_nettype wire

// File: rtl/mult_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_sequencer
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//                Operands are reduced to magnitudes on start, iterated for 32
//                cycles, then signs are applied in FIX and HI/LO written.
//                Optional macro MULT_DIV_DIVIDE_EN enables DIV/DIVU.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_div_sequencer
  import mult_div_sequencer_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int ANBITS = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ANBITS-1:0] i_Funct,
  input  logic [NBITS-1:0]  i_rs_data,
  input  logic [NBITS-1:0]  i_rt_data,
  input  logic              i_mthi,
  input  logic              i_mtlo,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_done,
  output logic [NBITS-1:0]  o_hi,
  output logic [NBITS-1:0]  o_lo
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*NBITS-1:0]     acc_q, acc_d;
  logic [NBITS-1:0]       opnd_q, opnd_d;
  logic                   neg_lo_q, neg_lo_d;
  logic [NBITS-1:0]       hi_q, hi_d;
  logic [NBITS-1:0]       lo_q, lo_d;
  logic                   done_q, done_d;

  logic                   w_signed, w_rs_neg, w_rt_neg;
  logic [NBITS-1:0]       w_mag_rs, w_mag_rt;
  logic                   w_is_mult, w_is_div, w_accept;
  logic [2*NBITS-1:0]     w_step, w_prod;

`ifdef MULT_DIV_DIVIDE_EN
  logic                   is_div_q, is_div_d;
  logic                   neg_hi_q, neg_hi_d;
  logic [NBITS-1:0]       w_quot, w_rem;
`endif

  // Operand decode: signed ops have funct[0] clear; work on magnitudes
  always_comb begin
    w_signed  = ~i_Funct[0];
    w_rs_neg  = w_signed & i_rs_data[NBITS-1];
    w_rt_neg  = w_signed & i_rt_data[NBITS-1];
    w_mag_rs  = w_rs_neg ? -i_rs_data : i_rs_data;
    w_mag_rt  = w_rt_neg ? -i_rt_data : i_rt_data;
    w_is_mult = (i_Funct == ANBITS'(FUNCT_MULT)) || (i_Funct == ANBITS'(FUNCT_MULTU));
`ifdef MULT_DIV_DIVIDE_EN
    w_is_div  = (i_Funct == ANBITS'(FUNCT_DIV)) || (i_Funct == ANBITS'(FUNCT_DIVU));
`else
    w_is_div  = 1'b0;
`endif
    // Flush in IDLE squashes the start
    w_accept  = i_start & ~i_flush & (w_is_mult | w_is_div);
  end

  mult_div_iter #(.NBITS(NBITS)) u_iter (
`ifdef MULT_DIV_DIVIDE_EN
    .i_op_div  (is_div_q),
`endif
    .i_acc     (acc_q),
    .i_operand (opnd_q),
    .o_acc     (w_step)
  );

  // Sign fix-up of the final accumulator
  always_comb begin
    w_prod = neg_lo_q ? -acc_q : acc_q;
`ifdef MULT_DIV_DIVIDE_EN
    w_quot = neg_lo_q ? -acc_q[NBITS-1:0] : acc_q[NBITS-1:0];
    w_rem  = neg_hi_q ? -acc_q[2*NBITS-1:NBITS] : acc_q[2*NBITS-1:NBITS];
`endif
  end

  // Next-state, datapath and HI/LO update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
    is_div_d = is_div_q;
    neg_hi_d = neg_hi_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_mthi) hi_d = i_rs_data;
        if (i_mtlo) lo_d = i_rs_data;
        if (w_accept) begin
          state_d  = ST_CALC;
          cnt_d    = '0;
          neg_lo_d = w_rs_neg ^ w_rt_neg;
`ifdef MULT_DIV_DIVIDE_EN
          is_div_d = w_is_div;
          neg_hi_d = w_rs_neg;
          if (w_is_div) begin
            acc_d  = {{NBITS{1'b0}}, w_mag_rs};
            opnd_d = w_mag_rt;
          end else begin
            acc_d  = {{NBITS{1'b0}}, w_mag_rt};
            opnd_d = w_mag_rs;
          end
`else
          acc_d    = {{NBITS{1'b0}}, w_mag_rt};
          opnd_d   = w_mag_rs;
`endif
        end
      end
      ST_CALC: begin
        if (i_flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = w_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(STEP_COUNT - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!i_flush) begin
          done_d = 1'b1;
`ifdef MULT_DIV_DIVIDE_EN
          if (is_div_q) begin
            hi_d = w_rem;
            lo_d = w_quot;
          end else begin
            hi_d = w_prod[2*NBITS-1:NBITS];
            lo_d = w_prod[NBITS-1:0];
          end
`else
          hi_d = w_prod[2*NBITS-1:NBITS];
          lo_d = w_prod[NBITS-1:0];
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_lo_q <= neg_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MULT_DIV_DIVIDE_EN
      is_div_q <= is_div_d;
      neg_hi_q <= neg_hi_d;
`endif
    end
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule : mult_div_sequencer
`default_nettype wire

// File: tb/tb_mult_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_sequencer
//  Description : Self-checking bench for mult_div_sequencer: directed vector
//                table, multi-cycle corner sequences and random operations
//                checked against an arithmetic reference model.
//                Honours MULT_DIV_DIVIDE_EN the same way as the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_div_sequencer;
  import mult_div_sequencer_pkg::*;

`ifdef MULT_DIV_DIVIDE_EN
  localparam bit DIV_IGN = 1'b0;
`else
  localparam bit DIV_IGN = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs, rt;
  logic        mthi, mtlo, flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_hi, model_lo;

  always #5 clk = ~clk;

  mult_div_sequencer #(.NBITS(32), .ANBITS(6)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_Funct   (funct),
    .i_rs_data (rs),
    .i_rt_data (rt),
    .i_mthi    (mthi),
    .i_mtlo    (mtlo),
    .i_flush   (flush),
    .o_busy    (busy),
    .o_done    (done),
    .o_hi      (hi),
    .o_lo      (lo)
  );

  typedef struct packed {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ign;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Architectural result {HI, LO} from plain arithmetic
  function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              si, ti;
    logic [63:0]     r;
    r = '0;
    case (f)
      FUNCT_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 64'(sa * sb);
      end
      FUNCT_MULTU: begin
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = ua * ub;
      end
      FUNCT_DIVU: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else        r = {a % b, a / b};
      end
      FUNCT_DIV: begin
        if (b == 0)                                   r = {a, (a[31] ? 32'h1 : 32'hFFFFFFFF)};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else begin
          si = $signed(a);
          ti = $signed(b);
          r  = {32'(si % ti), 32'(si / ti)};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Drive a start at the current negedge; returns at the negedge after acceptance
  task automatic launch(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    funct = f;
    rs    = a;
    rt    = b;
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
  endtask

  // Wait for o_done (bounded); check busy length and final HI/LO
  task automatic wait_done(input string name, input logic [31:0] eh, input logic [31:0] el);
    int busy_n = 0;
    bit seen   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      @(negedge clk);
    end
    chk({name, ".done"}, 64'(seen), 64'd1);
    chk({name, ".busy_cycles"}, 64'(busy_n), 64'd33);
    chk({name, ".hi"}, 64'(hi), 64'(eh));
    chk({name, ".lo"}, 64'(lo), 64'(el));
    model_hi = eh;
    model_lo = el;
  endtask

  // Start that must be ignored: no busy, no done, HI/LO unchanged
  task automatic expect_ignored(input string name, input logic [5:0] f,
                                input logic [31:0] a, input logic [31:0] b);
    bit act = 1'b0;
    launch(f, a, b);
    chk({name, ".busy"}, 64'(busy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      if (busy || done) act = 1'b1;
      @(negedge clk);
    end
    chk({name, ".activity"}, 64'(act), 64'd0);
    chk({name, ".hi"}, 64'(hi), 64'(model_hi));
    chk({name, ".lo"}, 64'(lo), 64'(model_lo));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [5:0]  fsel[4];
    logic [63:0] exp;
    logic [31:0] ra, rb;
    logic [5:0]  rf;
    bit          seen_done;

    vecs[0] = '{FUNCT_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1] = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_IGN};
    vecs[3] = '{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_IGN};
    vecs[4] = '{FUNCT_DIVU,  32'd9,        32'd0,        32'd9,        32'hFFFFFFFF, DIV_IGN};
    vecs[5] = '{FUNCT_DIV,   32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'h00000001, DIV_IGN};
    fsel[0] = FUNCT_MULT;
    fsel[1] = FUNCT_MULTU;
    fsel[2] = FUNCT_DIV;
    fsel[3] = FUNCT_DIVU;

    rst_n = 1'b0; start = 1'b0; funct = '0; rs = '0; rt = '0;
    mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    model_hi = '0; model_lo = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vecs[i].ign) begin
        expect_ignored($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b);
      end else begin
        launch(vecs[i].f, vecs[i].a, vecs[i].b);
        wait_done($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
      end
    end

    // Back-to-back: next start issued in the o_done cycle
    @(negedge clk);
    launch(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("b2b.first", 32'hFFFFFFFE, 32'h00000001);
`ifdef MULT_DIV_DIVIDE_EN
    launch(FUNCT_DIVU, 32'd100, 32'd7);
    wait_done("b2b.second", 32'd2, 32'd14);
`else
    launch(FUNCT_MULT, 32'd100, 32'd7);
    wait_done("b2b.second", 32'd0, 32'd700);
`endif

    // Unrecognised funct
    @(negedge clk);
    expect_ignored("bad_funct", 6'b100000, 32'd3, 32'd4);

    // MTHI visible next cycle
    @(negedge clk);
    mthi = 1'b1; rs = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi.hi", 64'(hi), 64'h1234);
    model_hi = 32'h1234;

    // MULT with MTLO while busy and flush at cycle 10
    launch(FUNCT_MULT, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    mtlo = 1'b1; rs = 32'hDEAD;
    @(negedge clk);
    mtlo = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush.busy", 64'(busy), 64'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("flush.no_done", 64'(seen_done), 64'd0);
    chk("flush.hi", 64'(hi), 64'h1234);
    chk("flush.lo", 64'(lo), 64'(model_lo));

    // MTLO coincident with a start: write happens, op proceeds
    mtlo = 1'b1;
    launch(FUNCT_MULT, 32'd6, 32'd7);
    chk("mt_start.lo", 64'(lo), 64'd6);
    wait_done("mt_start", 32'd0, 32'd42);

    // Randomised operations against the reference model
    for (int n = 0; n < 24; n++) begin
      rf = fsel[$urandom_range(0, 3)];
      case ($urandom_range(0, 7))
        0:       ra = 32'h0;
        1:       ra = 32'hFFFFFFFF;
        2:       ra = 32'h80000000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'h80000000;
        default: rb = $urandom;
      endcase
      exp = ref_model(rf, ra, rb);
      @(negedge clk);
      if (DIV_IGN && (rf == FUNCT_DIV || rf == FUNCT_DIVU)) begin
        expect_ignored($sformatf("rnd%0d", n), rf, ra, rb);
      end else begin
        launch(rf, ra, rb);
        wait_done($sformatf("rnd%0d f=%0h a=%0h b=%0h", n, rf, ra, rb), exp[63:32], exp[31:0]);
      end
    end

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
`ifdef MULT_DIV_DIVIDE_EN
    launch(FUNCT_DIV, 32'h12345678, 32'd3);
`else
    launch(FUNCT_MULT, 32'h12345678, 32'd3);
`endif
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.hi", 64'(hi), 64'd0);
    chk("arst.lo", 64'(lo), 64'd0);
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_hi = '0;
    model_lo = '0;

    // Recovery after reset
    @(negedge clk);
    launch(FUNCT_MULTU, 32'd6, 32'd7);
    wait_done("recover", 32'd0, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mult_div_sequencer
`default_nettype wire
